// File: rtl/alu_bcd_pkg.sv
// alu_bcd_pkg: shared BCD constants and converter state type
package alu_bcd_pkg;
   localparam int DIG_W = 4;
   localparam logic [DIG_W-1:0] BCD_MAX     = 4'd9;
   localparam logic [DIG_W-1:0] CORR_THRESH = 4'd8;
   localparam logic [DIG_W-1:0] CORR_SUB    = 4'd3;
   typedef enum logic [1:0] {IDLE, CONV, DONE} bcd2bin_state_t;
endpackage

// File: rtl/bcd_digit_correct.sv
// bcd_digit_correct: reverse double-dabble digit fix-up (d>=8 ? d-3 : d)
module bcd_digit_correct
   import alu_bcd_pkg::*;
(
   input  logic [DIG_W-1:0] d,
   output logic [DIG_W-1:0] q
);
   assign q = (d >= CORR_THRESH) ? d - CORR_SUB : d;
endmodule

// File: rtl/bcd_to_binary_converter.sv
// bcd_to_binary_converter: sequential BCD-to-binary conversion, one iteration per clock.
// Optional input digit check enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_binary_converter
   import alu_bcd_pkg::*;
#(
   parameter int NDIG  = 3,
   parameter int BIN_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIG_W*NDIG-1:0] bcd_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  ovf,
   output logic                  err_digit,
   output logic                  busy
);
   localparam int BW = DIG_W * NDIG;
   localparam int SW = BW + BIN_W;
   localparam int CW = $clog2(BIN_W);

   bcd2bin_state_t state, state_n;
   logic [SW-1:0]  sreg, sreg_n, shifted;
   logic [BW-1:0]  corr;
   logic [CW-1:0]  cnt, cnt_n;

   assign shifted = sreg >> 1;

   for (genvar g = 0; g < NDIG; g++) begin : g_corr
      bcd_digit_correct u_corr (
         .d(shifted[BIN_W + g*DIG_W +: DIG_W]),
         .q(corr[g*DIG_W +: DIG_W])
      );
   end

`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic err, err_n, bad;

   // flag any incoming digit above 9
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < NDIG; i++)
         if (bcd_in[i*DIG_W +: DIG_W] > BCD_MAX) bad = 1'b1;
   end
`endif

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
         err   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         sreg  <= sreg_n;
         cnt   <= cnt_n;
`ifdef BCD2BIN_DIGIT_CHECK_EN
         err   <= err_n;
`endif
      end
   end

   // next-state: load on accept, shift-and-correct in CONV, hold in DONE
   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      cnt_n   = cnt;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_n   = err;
`endif
      case (state)
         IDLE: if (in_valid) begin
            sreg_n  = {bcd_in, {BIN_W{1'b0}}};
            cnt_n   = '0;
            state_n = CONV;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_n   = bad;
`endif
         end
         CONV: begin
            sreg_n  = {corr, shifted[BIN_W-1:0]};
            cnt_n   = cnt + 1'b1;
            state_n = (cnt == CW'(BIN_W-1)) ? DONE : CONV;
         end
         DONE: state_n = out_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = !in_ready;

`ifdef BCD2BIN_DIGIT_CHECK_EN
   assign err_digit = out_valid & err;
   assign bin_out   = (out_valid && !err) ? sreg[BIN_W-1:0] : '0;
   assign ovf       = out_valid & !err & (|sreg[SW-1:BIN_W]);
`else
   assign err_digit = 1'b0;
   assign bin_out   = out_valid ? sreg[BIN_W-1:0] : '0;
   assign ovf       = out_valid & (|sreg[SW-1:BIN_W]);
`endif
endmodule
